rpi_irq_scheduler: RTL and testbench
====================================

# rpi_irq_scheduler

Sequencer for the Raspberry Pi interrupt clock in the I2S bridge. It counts audio samples landing in the sample buffer and, once a full burst is available, runs a gated, divided interrupt clock for exactly one burst of edges. It then waits for the Pi's acknowledge, retires the burst, and repeats. It owns the enable/divider sequencing for the Pi interrupt pin and reports overflow and acknowledge-timeout faults.

## Interface
- BURST_LEN, 16: samples retired per burst; also the number of irq_clk periods emitted per burst; range 1..255.
- DIV_LOG2, 6: irq_clk period is 2^DIV_LOG2 clk_in cycles.
- CNT_W, 8: width of the pending-sample counter.
- TIMEOUT, 4096: clk_in cycles allowed in WAIT_ACK before the burst is abandoned; minimum 8.

Ports:
- clk_in  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- sample_strobe  in  1  one-cycle pulse per stereo sample written to the buffer.
- rpi_ack  in  1  acknowledge from a Pi GPIO, asynchronous to clk_in.
- err_clear  in  1  one-cycle pulse; clears the overflow and timeout_err sticky bits.
- irq_clk  out  1  interrupt clock to the Pi.
- irq_active  out  1  high in BURST and WAIT_ACK.
- pending  out  CNT_W  samples not yet retired.
- burst_done  out  1  one-cycle pulse when a burst is retired.
- overflow  out  1  sticky: a sample arrived while pending was saturated.
- timeout_err  out  1  sticky: a WAIT_ACK timed out.

## Operation
- **Reset.** State is IDLE. pending, the divider, the edge count, the timeout counter, the synchronizer flops, overflow and timeout_err are all 0. Every output is 0.
- **pending counter.**
  - +1 on sample_strobe.
  - −BURST_LEN on the cycle the FSM leaves WAIT_ACK (ack or timeout).
  - If both happen in the same cycle, the net change is +1−BURST_LEN.
  - At 2^CNT_W−1 an increment is dropped and overflow is set. Saturation applies to the increment only; a simultaneous retire still subtracts.
- **rpi_ack path.** Synchronized by two flops, then registered again for edge detect. A rising edge is recognised in the third clk_in cycle after the pin rises. Edges outside WAIT_ACK are ignored.
- **FSM states:**
  - IDLE: if pending ≥ BURST_LEN, go to BURST. On entry the divider and edge count clear to 0.
  - BURST: the DIV_LOG2-bit divider increments every cycle, and irq_clk = divider MSB. Each wrap of the divider from all-ones to 0 increments the edge count. When the edge count reaches BURST_LEN (on the wrap), go to WAIT_ACK. irq_clk is then low.
  - WAIT_ACK: irq_clk is held 0 and the timeout counter increments.
    - Ack rising edge → IDLE, retire the burst, pulse burst_done.
    - Timeout counter reaches TIMEOUT−1 without an ack → IDLE, retire the burst, set timeout_err, pulse burst_done.
    - Ack and timeout in the same cycle: ack wins and timeout_err is not set.
- **err_clear.** Clears the sticky bits. If it coincides with a new set event, set wins.
- **Reset mid-burst.** Behaves exactly as power-on reset: irq_clk drops to 0 in the next cycle and pending is lost.

## Timing
- **IDLE → BURST decision.** pending ≥ BURST_LEN is evaluated on registered pending. A sample_strobe at cycle t makes pending visible at t+1. BURST is entered at t+2 if that sample crossed the threshold.
- **irq_clk waveform.** Registered, 50% duty, starts low.
  - First rising edge: 2^(DIV_LOG2−1) cycles after BURST entry (32 with defaults).
  - Time in BURST: exactly BURST_LEN·2^DIV_LOG2 cycles (1024 with defaults).
- **irq_active.** Rises on the first BURST cycle and falls on the first IDLE cycle.
- **burst_done.** High in the first IDLE cycle after WAIT_ACK, coincident with pending showing the decremented value.
- **Back-to-back bursts.** If pending is still ≥ BURST_LEN after a retire, BURST is re-entered one cycle later. irq_clk shows at least 2^(DIV_LOG2−1)+1 low cycles between bursts.
- **Ack latency.** Pin high → IDLE in 4 cycles from the rpi_ack transition (3 for synchronize and detect, then the state register).

## Test plan
- **Reset defaults:** reset for 3 cycles, then 100 idle cycles → all outputs 0 and irq_clk never toggles.
- **Single burst:** 16 strobes, 1 per 10 cycles → BURST entered 2 cycles after the 16th strobe. irq_clk shows 16 periods of 64 cycles, first rise 32 cycles after entry, then stays low. Raise rpi_ack 50 cycles later → burst_done 4 cycles after the rise and pending = 0.
- **Timeout:** 16 strobes and no ack → exactly 4096 WAIT_ACK cycles, then timeout_err = 1, pending = 0 and burst_done pulses. A later err_clear → timeout_err = 0.
- **Simultaneous strobe and retire:** pending = 20 and a strobe on the ack-retire cycle → pending = 5. A strobe during BURST still counts.
- **Saturation:** CNT_W = 4, BURST_LEN = 8, ack held low, 20 strobes → pending sticks at 15 and overflow = 1. An ack then → pending = 7. A strobe coincident with that retire cycle → pending = 8.
- **Reset mid-operation:** reset 300 cycles into a BURST → irq_clk = 0 and state IDLE one cycle later. After 16 new strobes the next burst emits a full 16 periods.

Source files
------------

// File: rtl/rpi_irq_scheduler.sv
// Sequences the Raspberry Pi interrupt clock: counts buffered samples, emits one gated,
// divided irq_clk burst per BURST_LEN samples, then waits for the Pi's ack or a timeout.
module rpi_irq_scheduler #(
  parameter int BURST_LEN = 16,
  parameter int DIV_LOG2  = 6,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sample_strobe,
  input  logic             rpi_ack,
  input  logic             err_clear,
  output logic             irq_clk,
  output logic             irq_active,
  output logic [CNT_W-1:0] pending,
  output logic             burst_done,
  output logic             overflow,
  output logic             timeout_err,
  output logic [1:0]       o_dbg_state
);

  // Handshake: sample_strobe and err_clear are single-cycle pulses with no back-pressure;
  // rpi_ack is a level from the Pi whose synchronized rising edge retires a burst in WAIT_ACK.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BURST    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  localparam int               TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BL_CNT   = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       BL_LAST  = 8'(BURST_LEN - 1);

  state_t r_state;
  state_t w_next;

  logic [DIV_LOG2-1:0] r_div;
  logic [7:0]          r_edges;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_ack_s1;
  logic                r_ack_s2;
  logic                r_ack_d;
  logic                r_ack_rise;
  logic [CNT_W-1:0]    r_pending;
  logic                r_burst_done;
  logic                r_overflow;
  logic                r_timeout_err;

  logic             w_wrap;
  logic             w_burst_end;
  logic             w_tmo_hit;
  logic             w_retire;
  logic             w_tmo_fault;
  logic             w_inc;
  logic             w_drop;
  logic [CNT_W-1:0] w_add;
  logic [CNT_W-1:0] w_sub;

  assign w_wrap      = (r_state == ST_BURST) && (r_div == '1);
  assign w_burst_end = w_wrap && (r_edges == BL_LAST);
  assign w_tmo_hit   = (r_tmo == TMO_LAST);
  assign w_retire    = (r_state == ST_WAIT_ACK) && (r_ack_rise || w_tmo_hit);
  assign w_tmo_fault = (r_state == ST_WAIT_ACK) && !r_ack_rise && w_tmo_hit;
  // A saturated counter still accepts the increment when a retire makes room the same cycle.
  assign w_inc       = sample_strobe && ((r_pending != CNT_MAX) || w_retire);
  assign w_drop      = sample_strobe && !w_inc;
  assign w_add       = w_inc ? CNT_W'(1) : '0;
  assign w_sub       = w_retire ? BL_CNT : '0;

  always_ff @(posedge clk_in) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (r_pending >= BL_CNT) w_next = ST_BURST;
      ST_BURST:    if (w_burst_end)         w_next = ST_WAIT_ACK;
      ST_WAIT_ACK: if (w_retire)            w_next = ST_IDLE;
      default:                              w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_div         <= '0;
      r_edges       <= '0;
      r_tmo         <= '0;
      r_ack_s1      <= 1'b0;
      r_ack_s2      <= 1'b0;
      r_ack_d       <= 1'b0;
      r_ack_rise    <= 1'b0;
      r_pending     <= '0;
      r_burst_done  <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ack_s1   <= rpi_ack;
      r_ack_s2   <= r_ack_s1;
      r_ack_d    <= r_ack_s2;
      r_ack_rise <= r_ack_s2 && !r_ack_d;

      // Divider and edge count sit at zero outside BURST, so every burst starts clean.
      if (r_state == ST_BURST) r_div <= r_div + DIV_LOG2'(1);
      else                     r_div <= '0;

      if (r_state != ST_BURST) r_edges <= '0;
      else if (w_wrap)         r_edges <= r_edges + 8'd1;

      if (r_state == ST_WAIT_ACK) r_tmo <= r_tmo + TMO_W'(1);
      else                        r_tmo <= '0;

      r_pending    <= r_pending + w_add - w_sub;
      r_burst_done <= w_retire;

      if (w_drop)         r_overflow <= 1'b1;
      else if (err_clear) r_overflow <= 1'b0;

      if (w_tmo_fault)    r_timeout_err <= 1'b1;
      else if (err_clear) r_timeout_err <= 1'b0;
    end
  end

  always_comb begin
    irq_clk     = r_div[DIV_LOG2-1];
    irq_active  = (r_state != ST_IDLE);
    pending     = r_pending;
    burst_done  = r_burst_done;
    overflow    = r_overflow;
    timeout_err = r_timeout_err;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_rpi_irq_scheduler.sv
// Directed bench for rpi_irq_scheduler: a default-parameter instance for burst, ack, timeout
// and reset behaviour, and a small-counter instance for saturation.
module tb_rpi_irq_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, strobe, ack, err_clear;
  logic       irq_clk, irq_active, burst_done, overflow, timeout_err;
  logic [7:0] pending;
  logic [1:0] dbg;

  logic       s_strobe, s_ack, s_err_clear;
  logic       s_irq_clk, s_irq_active, s_burst_done, s_overflow, s_timeout_err;
  logic [3:0] s_pending;
  logic [1:0] s_dbg;

  int n_total = 0;
  int n_bad   = 0;

  rpi_irq_scheduler dut (
    .clk_in(clk), .reset(reset), .sample_strobe(strobe), .rpi_ack(ack),
    .err_clear(err_clear), .irq_clk(irq_clk), .irq_active(irq_active),
    .pending(pending), .burst_done(burst_done), .overflow(overflow),
    .timeout_err(timeout_err), .o_dbg_state(dbg)
  );

  rpi_irq_scheduler #(.BURST_LEN(8), .CNT_W(4)) dut_s (
    .clk_in(clk), .reset(reset), .sample_strobe(s_strobe), .rpi_ack(s_ack),
    .err_clear(s_err_clear), .irq_clk(s_irq_clk), .irq_active(s_irq_active),
    .pending(s_pending), .burst_done(s_burst_done), .overflow(s_overflow),
    .timeout_err(s_timeout_err), .o_dbg_state(s_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input bit sel, input logic [1:0] st, input int budget, input string tag);
    int n;
    logic [1:0] cur;
    n = 0;
    cur = sel ? s_dbg : dbg;
    while (cur != st && n < budget) begin
      tick();
      n++;
      cur = sel ? s_dbg : dbg;
    end
    check(tag, 32'(cur), 32'(st));
  endtask

  task automatic measure_burst(output int len, output int first, output int rises);
    logic prev;
    prev = 1'b0; len = 0; first = -1; rises = 0;
    while (dbg == 2'd1 && len < 2000) begin
      if (irq_clk && !prev) begin
        rises++;
        if (first < 0) first = len;
      end
      prev = irq_clk;
      tick();
      len++;
    end
  endtask

  initial begin
    int len, first, rises, n;
    logic seen;

    reset = 1'b1; strobe = 1'b0; ack = 1'b0; err_clear = 1'b0;
    s_strobe = 1'b0; s_ack = 1'b0; s_err_clear = 1'b0;

    // reset defaults
    repeat (3) tick();
    reset = 1'b0;
    check("rst_state", 32'(dbg), 0);
    check("rst_outs", {26'b0, irq_clk, irq_active, burst_done, overflow, timeout_err, |pending}, 0);
    seen = 1'b0;
    repeat (100) begin
      tick();
      seen = seen | irq_clk | irq_active | burst_done | overflow | timeout_err | (|pending);
    end
    check("idle_quiet", 32'(seen), 0);

    // single burst, one strobe per 10 cycles
    for (int i = 0; i < 16; i++) begin
      repeat (9) tick();
      strobe = 1'b1; tick(); strobe = 1'b0;
    end
    check("sb_pending16", 32'(pending), 16);
    check("sb_still_idle", 32'(dbg), 0);
    tick();
    check("sb_enter_burst", 32'(dbg), 1);
    check("sb_active", 32'(irq_active), 1);
    check("sb_clk_starts_low", 32'(irq_clk), 0);
    measure_burst(len, first, rises);
    check("sb_len", 32'(len), 1024);
    check("sb_first_rise", 32'(first), 32);
    check("sb_rises", 32'(rises), 16);
    check("sb_wait_ack", 32'(dbg), 2);
    seen = 1'b0;
    repeat (50) begin
      tick();
      seen = seen | irq_clk;
    end
    check("sb_clk_low_wait", 32'(seen), 0);
    ack = 1'b1;
    n = 0;
    while (!burst_done && n < 10) begin
      tick();
      n++;
    end
    check("sb_ack_latency", 32'(n), 4);
    check("sb_pending0", 32'(pending), 0);
    check("sb_idle", 32'(dbg), 0);
    check("sb_inactive", 32'(irq_active), 0);
    tick();
    check("sb_done_pulse", 32'(burst_done), 0);
    ack = 1'b0;
    repeat (5) tick();

    // timeout
    strobe = 1'b1; repeat (16) tick(); strobe = 1'b0;
    check("to_pending16", 32'(pending), 16);
    wait_state(1'b0, 2'd2, 1200, "to_reach_wait");
    check("to_err_before", 32'(timeout_err), 0);
    n = 0;
    while (dbg == 2'd2 && n < 5000) begin
      tick();
      n++;
    end
    check("to_wait_cycles", 32'(n), 4096);
    check("to_err_set", 32'(timeout_err), 1);
    check("to_pending0", 32'(pending), 0);
    check("to_done", 32'(burst_done), 1);
    tick();
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("to_err_cleared", 32'(timeout_err), 0);

    // strobe during BURST and strobe coincident with retire
    strobe = 1'b1; repeat (16) tick(); strobe = 1'b0;
    wait_state(1'b0, 2'd1, 5, "sim_enter_burst");
    for (int i = 0; i < 4; i++) begin
      strobe = 1'b1; tick(); strobe = 1'b0;
      repeat (4) tick();
    end
    check("sim_pending20", 32'(pending), 20);
    wait_state(1'b0, 2'd2, 1100, "sim_reach_wait");
    ack = 1'b1;
    repeat (3) tick();
    check("sim_still_wait", 32'(dbg), 2);
    strobe = 1'b1; tick(); strobe = 1'b0;
    check("sim_done", 32'(burst_done), 1);
    check("sim_pending5", 32'(pending), 5);
    ack = 1'b0;
    repeat (5) tick();
    check("sim_stays_idle", 32'(dbg), 0);

    // reset in the middle of a burst
    strobe = 1'b1; repeat (11) tick(); strobe = 1'b0;
    wait_state(1'b0, 2'd1, 5, "rm_enter_burst");
    repeat (300) tick();
    check("rm_clk_high", 32'(irq_clk), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rm_clk_low", 32'(irq_clk), 0);
    check("rm_idle", 32'(dbg), 0);
    check("rm_pending0", 32'(pending), 0);
    strobe = 1'b1; repeat (16) tick(); strobe = 1'b0;
    wait_state(1'b0, 2'd1, 5, "rm_reenter_burst");
    measure_burst(len, first, rises);
    check("rm_len", 32'(len), 1024);
    check("rm_rises", 32'(rises), 16);
    ack = 1'b1;
    wait_state(1'b0, 2'd0, 10, "rm_ack_idle");
    ack = 1'b0;

    // saturation on the 4-bit, 8-sample instance
    s_strobe = 1'b1; repeat (20) tick(); s_strobe = 1'b0;
    check("sat_pending15", 32'(s_pending), 15);
    check("sat_overflow", 32'(s_overflow), 1);
    wait_state(1'b1, 2'd2, 600, "sat_reach_wait");
    s_ack = 1'b1;
    repeat (4) tick();
    check("sat_done", 32'(s_burst_done), 1);
    check("sat_pending7", 32'(s_pending), 7);
    s_ack = 1'b0;
    s_err_clear = 1'b1; tick(); s_err_clear = 1'b0;
    check("sat_ovf_cleared", 32'(s_overflow), 0);
    s_strobe = 1'b1; repeat (8) tick(); s_strobe = 1'b0;
    check("sat_refill15", 32'(s_pending), 15);
    check("sat_no_ovf", 32'(s_overflow), 0);
    s_strobe = 1'b1; s_err_clear = 1'b1; tick(); s_strobe = 1'b0; s_err_clear = 1'b0;
    check("sat_set_wins", 32'(s_overflow), 1);
    check("sat_hold15", 32'(s_pending), 15);
    wait_state(1'b1, 2'd2, 600, "sat_reach_wait2");
    s_ack = 1'b1;
    repeat (3) tick();
    s_strobe = 1'b1; tick(); s_strobe = 1'b0;
    check("sat_done2", 32'(s_burst_done), 1);
    check("sat_pending8", 32'(s_pending), 8);
    s_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
